fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CLKS_PER_BIT SHALL default to 4: number of clk cycles per serial bit, legal range 2..65535.
REQ-003 Parameter PARITY_EN SHALL default to 0: 1 inserts one even-parity bit after the data bits.
REQ-004 Port clk SHALL be an input of width 1: rising-edge clock for all state.
REQ-005 Port rst SHALL be an input of width 1: asynchronous active-high reset.
REQ-006 Port fifo_empty SHALL be an input of width 1: empty flag from the upstream synchronous FIFO.
REQ-007 Port fifo_data SHALL be an input of width 8: FIFO read data, valid the cycle after a fifo_ren=1 cycle.
REQ-008 Port fifo_ren SHALL be an output of width 1: FIFO read enable, one-cycle pulse per byte.
REQ-009 Port tx SHALL be an output of width 1: serial line, idle high.
REQ-010 Port busy SHALL be an output of width 1: high in every state except IDLE.
REQ-011 Port frame_done SHALL be an output of width 1: one-cycle pulse in the cycle after the last stop-bit cycle.

Function
REQ-012 The FSM SHALL have states IDLE, READ, LATCH, START, DATA, PARITY and STOP, and all outputs SHALL be registered or Moore-decoded from state.
REQ-013 In IDLE with fifo_empty=0 sampled at a clk edge, the FSM SHALL move to READ; with fifo_empty=1 it SHALL stay in IDLE.
REQ-014 fifo_ren SHALL be 1 in exactly one cycle, the READ cycle, and 0 in all other cycles.
REQ-015 READ SHALL always go to LATCH, regardless of fifo_empty.
REQ-016 The edge ending LATCH SHALL capture fifo_data into an 8-bit shift register and enter START.
REQ-017 tx SHALL be 0 for CLKS_PER_BIT cycles in START.
REQ-018 DATA SHALL drive shift-register bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit index that ends after bit 7.
REQ-019 PARITY SHALL only be entered when PARITY_EN=1; it SHALL drive the XOR of the 8 latched bits for CLKS_PER_BIT cycles.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE with frame_done=1 in that first IDLE cycle.
REQ-021 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on every bit boundary, and never wrap mid-bit.
REQ-022 Frame length from first START cycle to last STOP cycle SHALL be (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-023 The fifo_empty-low to first tx=0 latency SHALL be 3 cycles (IDLE sample, READ, LATCH).
REQ-024 Back-to-back: if fifo_empty=0 in the frame_done cycle, the next READ SHALL follow immediately, giving 3 tx-high cycles between frames beyond STOP.
REQ-025 fifo_empty changes outside IDLE SHALL be ignored, and a byte in flight SHALL always complete.
REQ-026 tx SHALL be 1 in IDLE, READ and LATCH.

Reset
REQ-027 When rst=1, the block SHALL immediately, without clk, force state=IDLE, tx=1, fifo_ren=0, busy=0, frame_done=0, baud counter=0, bit index=0 and shift register=0x00.
REQ-028 Reset asserted mid-frame SHALL abort the frame, drop the byte (no re-read), and the first post-reset READ SHALL occur no earlier than the second clk edge after rst deasserts.

Verification
REQ-029 Scenario empty: rst released with fifo_empty=1 for 50 cycles -> fifo_ren stays 0, tx stays 1, busy stays 0.
REQ-030 Scenario single byte 0x01 at CLKS_PER_BIT=4, PARITY_EN=0 -> one fifo_ren pulse, then tx sequence start 0, 1, seven 0s, stop 1, each 4 cycles, for 40 cycles, then frame_done for 1 cycle.
REQ-031 Scenario back-to-back 0x01 then 0x02 -> two frames with LSB-first data 10000000 and 01000000, 3 idle-high cycles between the stop bit and the second start bit, and two fifo_ren pulses total.
REQ-032 Scenario parity with PARITY_EN=1 and byte 0xA5 -> parity bit 0, and a 44-cycle frame at CLKS_PER_BIT=4.
REQ-033 Scenario reset at cycle 15 of a 0xFF frame -> tx=1 and busy=0 in the same cycle without a clk edge; after release with fifo_empty=1, no further fifo_ren and tx stays 1.
REQ-034 Scenario fifo_empty rises during the LATCH cycle -> the frame still transmits the latched byte in full, then the FSM stays in IDLE.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls bytes from a synchronous FIFO and sends them as 8N1 UART frames,
// with an optional even-parity bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_ren,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, START, DATA, PARITY, STOP} state_t;
    state_t state, next;
    logic [15:0] baud;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic armed;
    logic bit_end;
    assign bit_end = baud == 16'(CLKS_PER_BIT - 1);
    // armed keeps IDLE from reading on the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud       <= '0;
            idx        <= '0;
            shreg      <= '0;
            frame_done <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= next;
            armed      <= 1'b1;
            frame_done <= state == STOP && bit_end;
            baud       <= (state inside {START, DATA, PARITY, STOP}) && !bit_end ? baud + 16'd1 : '0;
            if (state == LATCH) shreg <= fifo_data;
            if (state == DATA && bit_end) idx <= idx + 3'd1;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = armed && !fifo_empty ? READ : IDLE;
            READ:    next = LATCH;
            LATCH:   next = START;
            START:   next = bit_end ? DATA : START;
            DATA:    next = bit_end && idx == 3'd7 ? (PARITY_EN ? PARITY : STOP) : DATA;
            PARITY:  next = bit_end ? STOP : PARITY;
            STOP:    next = bit_end ? IDLE : STOP;
            default: next = IDLE;
        endcase
    end
    assign fifo_ren = state == READ;
    assign busy     = state != IDLE;
    assign tx       = state == START ? 1'b0 : state == DATA ? shreg[idx] : state == PARITY ? ^shreg : 1'b1;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; stimulus queues hand-computed line patterns,
// a monitor decodes each frame off tx and compares.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    typedef struct packed {logic [10:0] bits; logic [3:0] n;} exp_t;

    logic clk, rst;
    logic e0, e1, ren0, ren1, tx0, tx1, busy0, busy1, fd0, fd1;
    logic [7:0] d0, d1;
    logic [7:0] mem0[16], mem1[16];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    int rc0 = 0, rc1 = 0;
    int total = 0, bad = 0;
    exp_t q0[$], q1[$];
    int pos[2] = '{-1, -1};
    exp_t cur[2];
    logic [10:0] act[2];
    bit jitter[2];
    logic [1:0] txv, fdv;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .fifo_empty(e0), .fifo_data(d0),
        .fifo_ren(ren0), .tx(tx0), .busy(busy0), .frame_done(fd0));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .fifo_empty(e1), .fifo_data(d1),
        .fifo_ren(ren1), .tx(tx1), .busy(busy1), .frame_done(fd1));

    assign e0 = wr0 == rd0;
    assign e1 = wr1 == rd1;
    assign txv = {tx1, tx0};
    assign fdv = {fd1, fd0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous FIFO model: data valid the cycle after a read enable
    initial forever begin
        @(posedge clk);
        if (ren0) begin d0 <= mem0[rd0 % 16]; rd0 <= rd0 + 1; end
        if (ren1) begin d1 <= mem1[rd1 % 16]; rd1 <= rd1 + 1; end
    end

    initial forever begin
        @(negedge clk);
        if (ren0) rc0++;
        if (ren1) rc1++;
    end

    initial forever begin
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            if (rst) pos[g] = -1;
            else begin
                if (pos[g] < 0 && !txv[g]) begin
                    if (g == 0 && q0.size() > 0) cur[g] = q0.pop_front();
                    else if (g == 1 && q1.size() > 0) cur[g] = q1.pop_front();
                    else begin
                        total++; bad++;
                        $display("FAIL frame_unexpected dut%0d: got a start bit, required no frame", g);
                        cur[g] = '{bits: 11'h7fe, n: 4'd10};
                    end
                    pos[g] = 0; act[g] = '0; jitter[g] = 0;
                end
                if (pos[g] >= 0 && pos[g] < int'(cur[g].n) * CPB) begin
                    if (pos[g] % CPB == 0) act[g][pos[g] / CPB] = txv[g];
                    else if (act[g][pos[g] / CPB] !== txv[g]) jitter[g] = 1;
                    if (fdv[g]) jitter[g] = 1;
                    pos[g]++;
                end else if (pos[g] >= 0) begin
                    total++;
                    if (act[g] !== cur[g].bits || jitter[g]) begin
                        bad++;
                        $display("FAIL frame dut%0d: got bits %b unstable=%0d, required %b", g, act[g], jitter[g], cur[g].bits);
                    end
                    total++;
                    if (fdv[g] !== 1'b1 || txv[g] !== 1'b1) begin
                        bad++;
                        $display("FAIL frame_done dut%0d: got fd=%b tx=%b, required fd=1 tx=1", g, fdv[g], txv[g]);
                    end
                    pos[g] = -1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push0(input logic [7:0] b, input logic [10:0] bits);
        mem0[wr0 % 16] = b; q0.push_back('{bits: bits, n: 4'd10}); wr0++;
    endtask

    task automatic push1(input logic [7:0] b, input logic [10:0] bits);
        mem1[wr1 % 16] = b; q1.push_back('{bits: bits, n: 4'd11}); wr1++;
    endtask

    task automatic wait_fd(input int g);
        int c = 0;
        do begin @(negedge clk); c++; end while (!(g == 1 ? fd1 : fd0) && c < 300);
        if (!(g == 1 ? fd1 : fd0)) begin
            total++; bad++;
            $display("FAIL wait_frame_done dut%0d: got timeout after %0d cycles, required a pulse", g, c);
        end
    endtask

    initial begin
        int n, err, lat, gap;
        rst = 1'b1;
        #1;
        check("reset_tx", tx0, 1); check("reset_ren", ren0, 0);
        check("reset_busy", busy0, 0); check("reset_fd", fd0, 0);
        check("reset_tx_par", tx1, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        err = 0;
        repeat (50) begin @(negedge clk); if (ren0 || !tx0 || busy0 || ren1 || !tx1) err++; end
        check("empty_idle", err, 0);

        n = rc0;
        push0(8'h01, 11'b00_1000_0000_10);
        lat = 0;
        while (tx0 && lat < 20) begin @(negedge clk); lat++; end
        check("latency", lat, 3);
        wait_fd(0);
        check("single_ren", rc0 - n, 1);

        n = rc0;
        push0(8'h01, 11'b00_1000_0000_10);
        push0(8'h02, 11'b00_1000_0001_00);
        wait_fd(0);
        gap = 0;
        while (tx0 && gap < 20) begin gap++; @(negedge clk); end
        check("b2b_gap", gap, 3);
        wait_fd(0);
        check("b2b_ren", rc0 - n, 2);

        n = rc1;
        push1(8'hA5, 11'b101_0100_1010);
        push1(8'h07, 11'b110_0000_1110);
        wait_fd(1);
        wait_fd(1);
        check("parity_ren", rc1 - n, 2);

        push0(8'hFF, 11'b01_1111_1111_0);
        lat = 0;
        while (tx0 && lat < 20) begin @(negedge clk); lat++; end
        repeat (15) @(negedge clk);
        check("pre_reset_busy", busy0, 1);
        rst = 1'b1;
        #1;
        check("async_tx", tx0, 1); check("async_busy", busy0, 0); check("async_ren", ren0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = rc0; err = 0;
        repeat (30) begin @(negedge clk); if (!tx0 || busy0 || fd0) err++; end
        check("post_reset_idle", err, 0);
        check("post_reset_ren", rc0 - n, 0);

        n = rc0;
        push0(8'h3C, 11'b00_1001_1110_00);
        wait_fd(0);
        err = 0;
        repeat (20) begin @(negedge clk); if (!tx0 || busy0) err++; end
        check("latch_empty_idle", err, 0);
        check("latch_empty_ren", rc0 - n, 1);

        repeat (5) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
